// File: rtl/mips_pkg.sv
// Shared constants for the MIPS datapath: register indices, sizes and
// the default reset values of the pointer registers.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_GP   = 5'd28;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

endpackage

// File: rtl/mips_reg_word.sv
// One architectural register word with load enable and a per-instance
// reset value. Reset is asynchronous so the file snaps to its reset
// contents without waiting for a clock.
module mips_reg_word #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    // Hold the word; reset forces the instance's init value immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= RESET_VAL;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/mips_regfile.sv
// Architectural register file: r0 hardwired to zero, r1..r31 stored in
// individual words, two operand read ports with optional same-cycle
// forwarding and a debug read port that always shows stored contents.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] SP_INIT = SP_INIT_DEFAULT,
    parameter logic [WIDTH-1:0] GP_INIT = GP_INIT_DEFAULT,
    parameter int               BYPASS  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    output logic [WIDTH-1:0]      ra_data,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [WIDTH-1:0]      rb_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]      dbg_data
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic                           fwd_valid;

    // r0 has no storage at all.
    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_word
            localparam logic [REG_ADDR_W-1:0] IDX = REG_ADDR_W'(gi);
            localparam logic [WIDTH-1:0] INIT =
                (IDX == REG_GP) ? GP_INIT :
                (IDX == REG_SP) ? SP_INIT : '0;

            mips_reg_word #(
                .WIDTH     (WIDTH),
                .RESET_VAL (INIT)
            ) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (we && (waddr == IDX)),
                .d     (wdata),
                .q     (regs[gi])
            );
        end
    endgenerate

    // A forward is only legal for a real register outside reset, so that
    // reset contents and the zero register always win.
    assign fwd_valid = (BYPASS != 0) && rst_n && we && (waddr != REG_ZERO);

    // Operand port A: stored value, optionally replaced by the pending write.
    always_comb begin
        ra_data = regs[ra_addr];
        if (fwd_valid && (waddr == ra_addr)) begin
            ra_data = wdata;
        end
    end

    // Operand port B: same selection as port A.
    always_comb begin
        rb_data = regs[rb_addr];
        if (fwd_valid && (waddr == rb_addr)) begin
            rb_data = wdata;
        end
    end

    // Debug port: always the committed contents, never forwarded.
    always_comb begin
        dbg_data = regs[dbg_addr];
    end

endmodule
